dot_product_ctrl: RTL and testbench



---
 rtl/dot_ctrl_pkg.sv | 25 ++
 rtl/dot_product_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dot_product_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_ctrl_pkg.sv
// Shared types and constants for the dot_product sequencer.
package dot_ctrl_pkg;

    localparam int DEF_PE_COUNT = 4;
    localparam int DEF_ROW_W    = 16;
    localparam int DEF_CHUNK_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PAD  = 2'd2,
        OUT  = 2'd3
    } state_e;

    // Bit k is set when slot k of a group holds a real row; remaining counts rows from the group base.
    function automatic logic [31:0] calc_out_mask(input int remaining, input int pe_count);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            m[i] = (i < remaining) && (i < pe_count);
        end
        return m;
    endfunction

endpackage

// File: rtl/dot_product_ctrl.sv
// Sequencer driving dot_product: chunk accumulation, group writeback handshake.
// Define DOT_CTRL_PAD_EN to accept row counts that leave a partial final group (zero-padded).
module dot_product_ctrl
    import dot_ctrl_pkg::*;
#(
    parameter int PE_COUNT = DEF_PE_COUNT,
    parameter int ROW_W    = DEF_ROW_W,
    parameter int CHUNK_W  = DEF_CHUNK_W
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [ROW_W-1:0]    num_rows,
    input  logic [CHUNK_W-1:0]  num_chunks,
    output logic                busy,
    output logic                done,
    output logic                err,
    input  logic                pe_valid,
    output logic                pe_ready,
    output logic                dot_prod_en,
    output logic                shift,
    output logic                pad_zero,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ROW_W-1:0]    out_row_base,
    output logic [PE_COUNT-1:0] out_mask
);

    localparam int                SLOT_W    = $clog2(PE_COUNT);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PE_COUNT - 1);
    localparam logic [ROW_W-1:0]  ROW_LOW   = ROW_W'(PE_COUNT - 1);

    state_e              state_q;
    logic [CHUNK_W-1:0]  chunk_cnt_q;
    logic [CHUNK_W-1:0]  num_chunks_q;
    logic [ROW_W-1:0]    row_cnt_q;
    logic [ROW_W-1:0]    num_rows_q;
    logic [SLOT_W-1:0]   slot_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                out_valid_q;
    logic [PE_COUNT-1:0] out_mask_q;
    logic [ROW_W-1:0]    out_row_base_q;

    logic                first_chunk;
    logic                last_chunk;
    logic                cfg_bad;
    logic [SLOT_W-1:0]   slot_d;
    logic [ROW_W-1:0]    group_base;
    logic [PE_COUNT-1:0] group_mask;
`ifdef DOT_CTRL_PAD_EN
    logic                last_row;
`endif

    // slot_d is the write index the reduction unit will hold after the current accept.
    always_comb begin
        first_chunk = (chunk_cnt_q == '0);
        last_chunk  = (chunk_cnt_q == num_chunks_q - CHUNK_W'(1));
        slot_d      = first_chunk ? slot_q + SLOT_W'(1) : slot_q;
        group_base  = row_cnt_q & ~ROW_LOW;
`ifdef DOT_CTRL_PAD_EN
        last_row    = (row_cnt_q == num_rows_q - ROW_W'(1));
        group_mask  = PE_COUNT'(calc_out_mask(int'(32'(num_rows_q - group_base)), PE_COUNT));
        cfg_bad     = (num_rows == '0) || (num_chunks == '0);
`else
        group_mask  = '1;
        cfg_bad     = (num_rows == '0) || (num_chunks == '0) || ((num_rows & ROW_LOW) != '0);
`endif
    end

    always_comb begin
        pe_ready    = 1'b0;
        dot_prod_en = 1'b0;
        shift       = 1'b0;
        pad_zero    = 1'b0;
        unique case (state_q)
            RUN: begin
                pe_ready    = 1'b1;
                dot_prod_en = pe_valid;
                shift       = first_chunk;
            end
`ifdef DOT_CTRL_PAD_EN
            PAD: begin
                dot_prod_en = 1'b1;
                shift       = 1'b1;
                pad_zero    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= IDLE;
            chunk_cnt_q    <= '0;
            num_chunks_q   <= '0;
            row_cnt_q      <= '0;
            num_rows_q     <= '0;
            slot_q         <= SLOT_LAST;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_mask_q     <= '0;
            out_row_base_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q        <= 1'b0;
                            busy_q       <= 1'b1;
                            num_rows_q   <= num_rows;
                            num_chunks_q <= num_chunks;
                            chunk_cnt_q  <= '0;
                            row_cnt_q    <= '0;
                            state_q      <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (pe_valid) begin
                        slot_q <= slot_d;
                        if (last_chunk) begin
                            chunk_cnt_q <= '0;
                            row_cnt_q   <= row_cnt_q + ROW_W'(1);
                            if (slot_d == SLOT_LAST) begin
                                state_q        <= OUT;
                                out_valid_q    <= 1'b1;
                                out_row_base_q <= group_base;
                                out_mask_q     <= group_mask;
                            end
`ifdef DOT_CTRL_PAD_EN
                            else if (last_row) begin
                                state_q        <= PAD;
                                out_row_base_q <= group_base;
                                out_mask_q     <= group_mask;
                            end
`endif
                        end else begin
                            chunk_cnt_q <= chunk_cnt_q + CHUNK_W'(1);
                        end
                    end
                end
`ifdef DOT_CTRL_PAD_EN
                PAD: begin
                    slot_q <= slot_q + SLOT_W'(1);
                    if (slot_q + SLOT_W'(1) == SLOT_LAST) begin
                        state_q     <= OUT;
                        out_valid_q <= 1'b1;
                    end
                end
`endif
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (row_cnt_q == num_rows_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign out_valid    = out_valid_q;
    assign out_mask     = out_mask_q;
    assign out_row_base = out_row_base_q;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Randomized bench for dot_product_ctrl against a queue-of-expected-events job model.
module tb_dot_product_ctrl;

    localparam int PE      = 4;
    localparam int ROW_W   = 16;
    localparam int CHUNK_W = 8;
    localparam int K_ACCEPT = 0;
    localparam int K_PAD    = 1;
    localparam int K_GROUP  = 2;

    typedef struct {
        int kind;
        int shiftExp;
        int slotExp;
        int base;
        int mask;
    } item_t;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               start = 1'b0;
    logic [ROW_W-1:0]   num_rows = '0;
    logic [CHUNK_W-1:0] num_chunks = '0;
    logic               busy, done, err;
    logic               pe_valid = 1'b0;
    logic               pe_ready, dot_prod_en, shift, pad_zero;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [ROW_W-1:0]   out_row_base;
    logic [PE-1:0]      out_mask;

    int checks = 0;
    int failures = 0;
    int writeIdx = PE - 1;
    item_t q[$];

    dot_product_ctrl #(.PE_COUNT(PE), .ROW_W(ROW_W), .CHUNK_W(CHUNK_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .num_rows(num_rows), .num_chunks(num_chunks),
        .busy(busy), .done(done), .err(err), .pe_valid(pe_valid), .pe_ready(pe_ready),
        .dot_prod_en(dot_prod_en), .shift(shift), .pad_zero(pad_zero), .out_valid(out_valid),
        .out_ready(out_ready), .out_row_base(out_row_base), .out_mask(out_mask)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reduction-unit write pointer: advances whenever a new slot is opened.
    task automatic trackSlot(input int slotExp);
        if (dot_prod_en && shift) begin
            writeIdx = (writeIdx + 1) % PE;
            checkOutput("slot_order", 32'(writeIdx), 32'(slotExp));
        end
    endtask

    task automatic buildJob(input int rows, input int chunks);
        item_t it;
        int groups;
        int real_rows;
        q.delete();
        groups = (rows + PE - 1) / PE;
        for (int g = 0; g < groups; g++) begin
            real_rows = (rows - g * PE >= PE) ? PE : rows - g * PE;
            for (int r = 0; r < real_rows; r++) begin
                for (int c = 0; c < chunks; c++) begin
                    it = '{K_ACCEPT, (c == 0) ? 1 : 0, r, 0, 0};
                    q.push_back(it);
                end
            end
            for (int p = real_rows; p < PE; p++) begin
                it = '{K_PAD, 1, p, 0, 0};
                q.push_back(it);
            end
            it = '{K_GROUP, 0, 0, g * PE, (1 << real_rows) - 1};
            q.push_back(it);
        end
    endtask

    task automatic applyStimulus(input int rows, input int chunks, input int validPct,
                                 input int stall0, input bit pokeStart);
        item_t it;
        int cycles = 0;
        int groupIdx = 0;
        int stallLeft = stall0;
        buildJob(rows, chunks);
        start = 1'b1;
        num_rows = ROW_W'(rows);
        num_chunks = CHUNK_W'(chunks);
        pe_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (q.size() > 0 && cycles < 5000) begin
            cycles++;
            it = q[0];
            pe_valid = ($urandom_range(99) < validPct);
            if (it.kind == K_GROUP && groupIdx == 0 && stallLeft > 0) begin
                out_ready = 1'b0;
                stallLeft--;
            end else begin
                out_ready = ($urandom_range(99) < 70);
            end
            if (pokeStart) begin
                start = $urandom_range(1);
                num_rows = ROW_W'($urandom_range(3));
                num_chunks = CHUNK_W'($urandom_range(2));
            end
            @(negedge clk);
            checkOutput("busy", 32'(busy), 1);
            checkOutput("err_clear", 32'(err), 0);
            checkOutput("done_early", 32'(done), 0);
            if (it.kind == K_ACCEPT) begin
                checkOutput("run_pe_ready", 32'(pe_ready), 1);
                checkOutput("run_en", 32'(dot_prod_en), 32'(pe_valid));
                checkOutput("run_pad_zero", 32'(pad_zero), 0);
                checkOutput("run_out_valid", 32'(out_valid), 0);
                if (pe_valid) begin
                    checkOutput("run_shift", 32'(shift), 32'(it.shiftExp));
                    trackSlot(it.slotExp);
                    void'(q.pop_front());
                end
            end else if (it.kind == K_PAD) begin
                checkOutput("pad_en", 32'(dot_prod_en), 1);
                checkOutput("pad_shift", 32'(shift), 1);
                checkOutput("pad_zero", 32'(pad_zero), 1);
                checkOutput("pad_pe_ready", 32'(pe_ready), 0);
                checkOutput("pad_out_valid", 32'(out_valid), 0);
                trackSlot(it.slotExp);
                void'(q.pop_front());
            end else begin
                checkOutput("out_valid", 32'(out_valid), 1);
                checkOutput("out_row_base", 32'(out_row_base), 32'(it.base));
                checkOutput("out_mask", 32'(out_mask), 32'(it.mask));
                checkOutput("out_pe_ready", 32'(pe_ready), 0);
                checkOutput("out_en", 32'(dot_prod_en), 0);
                checkOutput("out_slot_aligned", 32'(writeIdx), 32'(PE - 1));
                if (out_ready) begin
                    groupIdx++;
                    void'(q.pop_front());
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        pe_valid = 1'b0;
        out_ready = 1'b0;
        checkOutput("job_within_budget", 32'(q.size()), 0);
        @(negedge clk);
        checkOutput("done_pulse", 32'(done), 1);
        checkOutput("idle_busy", 32'(busy), 0);
        checkOutput("idle_out_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("done_single", 32'(done), 0);
        @(posedge clk); #1;
    endtask

    task automatic rejectJob(input int rows, input int chunks);
        start = 1'b1;
        num_rows = ROW_W'(rows);
        num_chunks = CHUNK_W'(chunks);
        @(posedge clk); #1;
        start = 1'b0;
        pe_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rej_err", 32'(err), 1);
            checkOutput("rej_busy", 32'(busy), 0);
            checkOutput("rej_en", 32'(dot_prod_en), 0);
            checkOutput("rej_done", 32'(done), 0);
            @(posedge clk); #1;
        end
        pe_valid = 1'b0;
    endtask

    initial begin
        int rows;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_pe_ready", 32'(pe_ready), 0);
        checkOutput("rst_en", 32'(dot_prod_en), 0);
        checkOutput("rst_shift", 32'(shift), 0);
        checkOutput("rst_pad_zero", 32'(pad_zero), 0);
        checkOutput("rst_mask", 32'(out_mask), 0);
        checkOutput("rst_base", 32'(out_row_base), 0);
        @(posedge clk); #1;

        applyStimulus(4, 3, 100, 0, 1'b0);
        applyStimulus(8, 2, 100, 5, 1'b0);
`ifdef DOT_CTRL_PAD_EN
        applyStimulus(6, 1, 100, 0, 1'b0);
`else
        rejectJob(6, 1);
`endif
        rejectJob(0, 3);
        rejectJob(4, 0);

        start = 1'b1;
        num_rows = ROW_W'(4);
        num_chunks = CHUNK_W'(2);
        @(posedge clk); #1;
        start = 1'b0;
        pe_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("abort_pe_ready", 32'(pe_ready), 1);
            @(posedge clk); #1;
        end
        pe_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        writeIdx = PE - 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("abort_busy", 32'(busy), 0);
            checkOutput("abort_done", 32'(done), 0);
            checkOutput("abort_pe_ready", 32'(pe_ready), 0);
            @(posedge clk); #1;
        end
        applyStimulus(4, 1, 100, 0, 1'b0);

        applyStimulus(8, 2, 50, 0, 1'b1);

        for (int j = 0; j < 4; j++) begin
`ifdef DOT_CTRL_PAD_EN
            rows = int'($urandom_range(10, 1));
`else
            rows = PE * int'($urandom_range(3, 1));
`endif
            applyStimulus(rows, int'($urandom_range(3, 1)), 60, int'($urandom_range(3)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
